// File: rtl/audio_pwm_out.sv
// audio_pwm_out: bus-mapped sample FIFO drained at a fixed sample rate into a
// single-pin PWM DAC, with level/status registers and a low-water interrupt.
module audio_pwm_out #(
  parameter int SAMPLE_DIV = 1134,
  parameter int FIFO_DEPTH = 64,
  parameter int PWM_BITS   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        pwm_out,
  output logic        irq_low
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMR_W  = $clog2(SAMPLE_DIV);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(FIFO_DEPTH / 2);

  // Offset-binary conversion of a signed sample, keeping the top PWM_BITS.
  function automatic logic [PWM_BITS-1:0] to_duty(input logic signed [DATA_W-1:0] s);
    logic [DATA_W-1:0] u;
    u = s ^ 16'h8000;
    return u[DATA_W-1 -: PWM_BITS];
  endfunction

  logic signed [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic        [PTR_W-1:0]  wr_ptr;
  logic        [PTR_W-1:0]  rd_ptr;
  logic        [CNT_W-1:0]  count;
  logic signed [DATA_W-1:0] sample_p0;
  logic        [PWM_BITS-1:0] duty_p0;
  logic        [PWM_BITS-1:0] pwm_cnt;
  logic        [TMR_W-1:0]  timer;
  logic                     enable;
  logic                     underrun;
  logic                     overflow;

  logic [1:0]  sel;
  logic        wr_data, wr_status, wr_ctrl;
  logic        empty, full;
  logic        tick, pop, push, ovf_set, und_set;
  logic [31:0] status_word;
  logic        unused_bits;

  assign sel       = addr[3:2];
  assign wr_data   = we && (sel == 2'd0);
  assign wr_status = we && (sel == 2'd1);
  assign wr_ctrl   = we && (sel == 2'd2);

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // A full FIFO still accepts a push when the same cycle pops the head.
  assign tick    = enable && (timer == TMR_LAST);
  assign pop     = tick && !empty;
  assign push    = wr_data && (!full || pop);
  assign ovf_set = wr_data && full && !pop;
  assign und_set = tick && empty;

  assign duty_p0     = to_duty(sample_p0);
  assign status_word = {16'h0, 8'(count), 4'h0, overflow, underrun, full, empty};
  assign irq_low     = enable && (count <= CNT_HALF);
  assign unused_bits = ^{addr[31:4], addr[1:0], wd[31:16]};

  // Sample storage; contents survive reset and disable.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= $signed(wd[DATA_W-1:0]);
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage p0: current sample, loaded on each tick (midscale on underrun).
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_p0 <= '0;
    end else if (tick) begin
      sample_p0 <= pop ? fifo_mem[rd_ptr] : '0;
    end
  end

  // Sticky error flags and the enable bit; a same-cycle set beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
      enable   <= 1'b0;
    end else begin
      underrun <= (underrun && !(wr_status && wd[2])) || und_set;
      overflow <= (overflow && !(wr_status && wd[3])) || ovf_set;
      if (wr_ctrl) enable <= wd[0];
    end
  end

  // Sample-period timer; parked at zero while disabled.
  always_ff @(posedge clk) begin
    if (reset || !enable || tick) timer <= '0;
    else                          timer <= timer + 1'b1;
  end

  // PWM ramp restarts on every tick so each new duty begins a fresh period.
  always_ff @(posedge clk) begin
    if (reset || !enable || tick) pwm_cnt <= '0;
    else                          pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Stage p1: registered comparator output drives the DAC pin.
  always_ff @(posedge clk) begin
    if (reset) pwm_out <= 1'b0;
    else       pwm_out <= enable && (pwm_cnt < duty_p0);
  end

  // Registered read mux, sampled every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd <= '0;
    end else begin
      case (sel)
        2'd1:    rd <= status_word;
        2'd2:    rd <= {31'h0, enable};
        default: rd <= '0;
      endcase
    end
  end

endmodule
